// File: rtl/segre_history_file.sv
// segre_history_file: circular undo log giving precise exceptions across the EX/MEM/RVM pipelines.
// Optional retire/recovery counters are enabled by defining HF_STATS_EN.
module segre_history_file #(
    parameter int HF_SIZE   = 8,
    parameter int HF_PTR    = $clog2(HF_SIZE),
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 new_entry_i,
    input  logic [REG_SIZE-1:0]  dest_reg_i,
    input  logic [WORD_SIZE-1:0] rf_data_i,
    output logic [HF_PTR-1:0]    instr_id_o,
    input  logic                 ex_complete_i,
    input  logic [HF_PTR-1:0]    ex_complete_id_i,
    input  logic                 mem_complete_i,
    input  logic [HF_PTR-1:0]    mem_complete_id_i,
    input  logic                 rvm_complete_i,
    input  logic [HF_PTR-1:0]    rvm_complete_id_i,
    input  logic                 exception_i,
    input  logic [HF_PTR-1:0]    exception_id_i,
    output logic                 retire_o,
    output logic [HF_PTR-1:0]    retire_id_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 recovering_o,
    output logic                 rec_we_o,
    output logic [REG_SIZE-1:0]  rec_reg_o,
    output logic [WORD_SIZE-1:0] rec_value_o
`ifdef HF_STATS_EN
    ,
    output logic [31:0]          retired_cnt_o,
    output logic [31:0]          recovery_cnt_o
`endif
);
    typedef enum logic {HF_IDLE, HF_RECOVER} state_t;

    state_t                state, state_n;
    logic [HF_PTR-1:0]     head, tail, target, e;
    logic [HF_PTR:0]       count;
    logic [HF_SIZE-1:0]    valid, complete;
    logic [REG_SIZE-1:0]   dest [HF_SIZE];
    logic [WORD_SIZE-1:0]  value [HF_SIZE];
    logic                  undo, exc_take, alloc;

    assign undo         = state == HF_RECOVER;
    assign e            = tail - HF_PTR'(1);
    assign exc_take     = state == HF_IDLE && exception_i && valid[exception_id_i];
    assign full_o       = count == (HF_PTR+1)'(HF_SIZE) || undo;
    assign empty_o      = count == '0;
    // an accepted exception pre-empts both allocation and retirement
    assign alloc        = new_entry_i && !full_o && !exc_take;
    assign retire_o     = state == HF_IDLE && valid[head] && complete[head] && !exc_take;
    assign retire_id_o  = head;
    assign instr_id_o   = tail;
    assign recovering_o = undo;
    assign rec_we_o     = undo && dest[e] != '0;
    assign rec_reg_o    = undo ? dest[e] : '0;
    assign rec_value_o  = undo ? value[e] : '0;

    always_comb begin
        state_n = undo ? (e == target ? HF_IDLE : HF_RECOVER) : (exc_take ? HF_RECOVER : HF_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= HF_IDLE;
            head     <= '0;
            tail     <= '0;
            target   <= '0;
            count    <= '0;
            valid    <= '0;
            complete <= '0;
        end else begin
            state <= state_n;
            if (exc_take) target <= exception_id_i;
            if (!undo && ex_complete_i && valid[ex_complete_id_i]) complete[ex_complete_id_i] <= 1'b1;
            if (!undo && mem_complete_i && valid[mem_complete_id_i]) complete[mem_complete_id_i] <= 1'b1;
            if (!undo && rvm_complete_i && valid[rvm_complete_id_i]) complete[rvm_complete_id_i] <= 1'b1;
            if (retire_o) begin
                valid[head]    <= 1'b0;
                complete[head] <= 1'b0;
                head           <= head + HF_PTR'(1);
            end
            if (alloc) begin
                valid[tail]    <= 1'b1;
                complete[tail] <= 1'b0;
                tail           <= tail + HF_PTR'(1);
            end
            if (undo) begin
                valid[e]    <= 1'b0;
                complete[e] <= 1'b0;
                tail        <= e;
            end
            count <= count + (HF_PTR+1)'(alloc) - (HF_PTR+1)'(retire_o || undo);
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            dest[tail]  <= dest_reg_i;
            value[tail] <= rf_data_i;
        end
    end

`ifdef HF_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_cnt_o  <= '0;
            recovery_cnt_o <= '0;
        end else begin
            if (retire_o) retired_cnt_o <= retired_cnt_o + 32'd1;
            if (exc_take) recovery_cnt_o <= recovery_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_segre_history_file.sv
// tb_segre_history_file: table-driven directed vectors for segre_history_file,
// with hand-written sequences for reset during recovery and the HF_STATS_EN counters.
module tb_segre_history_file;
    localparam int N = -1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        new_entry_i;
    logic [4:0]  dest_reg_i;
    logic [31:0] rf_data_i;
    logic [2:0]  instr_id_o;
    logic        ex_complete_i, mem_complete_i, rvm_complete_i, exception_i;
    logic [2:0]  ex_complete_id_i, mem_complete_id_i, rvm_complete_id_i, exception_id_i;
    logic        retire_o, full_o, empty_o, recovering_o, rec_we_o;
    logic [2:0]  retire_id_o;
    logic [4:0]  rec_reg_o;
    logic [31:0] rec_value_o;
`ifdef HF_STATS_EN
    logic [31:0] retired_cnt_o, recovery_cnt_o;
`endif

    segre_history_file dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .new_entry_i(new_entry_i), .dest_reg_i(dest_reg_i), .rf_data_i(rf_data_i),
        .instr_id_o(instr_id_o),
        .ex_complete_i(ex_complete_i), .ex_complete_id_i(ex_complete_id_i),
        .mem_complete_i(mem_complete_i), .mem_complete_id_i(mem_complete_id_i),
        .rvm_complete_i(rvm_complete_i), .rvm_complete_id_i(rvm_complete_id_i),
        .exception_i(exception_i), .exception_id_i(exception_id_i),
        .retire_o(retire_o), .retire_id_o(retire_id_o),
        .full_o(full_o), .empty_o(empty_o), .recovering_o(recovering_o),
        .rec_we_o(rec_we_o), .rec_reg_o(rec_reg_o), .rec_value_o(rec_value_o)
`ifdef HF_STATS_EN
        , .retired_cnt_o(retired_cnt_o), .recovery_cnt_o(recovery_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // -1 in an id/register field means "strobe not asserted" / "no retire expected"
    typedef struct {
        int          dr;
        logic [31:0] dd;
        int          ce, cm, cr, ex;
        int          id, rid, full, empty, rec, we, rreg;
        logic [31:0] rval;
    } vec_t;

    vec_t q[$];
    int   total = 0;
    int   bad = 0;
    int   phase = 0;

    function automatic void add(int dr, logic [31:0] dd, int ce, int cm, int cr, int ex,
                                int id, int rid, int full, int empty, int rec, int we,
                                int rreg, logic [31:0] rval);
        q.push_back('{dr, dd, ce, cm, cr, ex, id, rid, full, empty, rec, we, rreg, rval});
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [47:0] got, exp;
        new_entry_i       = v.dr >= 0;
        dest_reg_i        = v.dr >= 0 ? 5'(v.dr) : 5'd0;
        rf_data_i         = v.dd;
        ex_complete_i     = v.ce >= 0;
        ex_complete_id_i  = v.ce >= 0 ? 3'(v.ce) : 3'd0;
        mem_complete_i    = v.cm >= 0;
        mem_complete_id_i = v.cm >= 0 ? 3'(v.cm) : 3'd0;
        rvm_complete_i    = v.cr >= 0;
        rvm_complete_id_i = v.cr >= 0 ? 3'(v.cr) : 3'd0;
        exception_i       = v.ex >= 0;
        exception_id_i    = v.ex >= 0 ? 3'(v.ex) : 3'd0;
        #1;
        exp = {3'(v.id), v.rid >= 0, v.rid >= 0 ? 3'(v.rid) : 3'd0, v.full != 0, v.empty != 0,
               v.rec != 0, v.we != 0, 5'(v.rreg), v.rval};
        got = {instr_id_o, retire_o, retire_o ? retire_id_o : 3'd0, full_o, empty_o,
               recovering_o, rec_we_o, rec_reg_o, rec_value_o};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL vec p%0d.%0d got=%h expected=%h", phase, idx, got, exp);
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run_table();
        foreach (q[i]) apply(q[i], i);
        q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        new_entry_i = 0; dest_reg_i = 0; rf_data_i = 0;
        ex_complete_i = 0; mem_complete_i = 0; rvm_complete_i = 0; exception_i = 0;
        ex_complete_id_i = 0; mem_complete_id_i = 0; rvm_complete_id_i = 0; exception_id_i = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        // fill to full, drop the 9th alloc, drain; then out-of-order completion
        phase = 1;
        do_reset();
        add(N, 0, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 32'h100 + i, N, N, N, N, i, N, 0, int'(i == 0), 0, 0, 0, 0);
        add(2, 32'hdead, N, N, N, N, 0, N, 1, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, N, 1, 0, 0, 0, 0, 0);
        add(N, 0, 0, 1, 2, N, 0, N, 1, 0, 0, 0, 0, 0);
        add(N, 0, 3, 4, 5, N, 0, 0, 1, 0, 0, 0, 0, 0);
        add(N, 0, 6, 7, N, N, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i < 8; i++) add(N, 0, N, N, N, N, 0, i, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        add(3, 32'h1, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        add(4, 32'h2, N, N, N, N, 1, N, 0, 0, 0, 0, 0, 0);
        add(5, 32'h3, N, N, N, N, 2, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, 2, N, N, N, 3, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, 0, N, N, N, 3, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, 1, N, N, N, 3, 0, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 3, 1, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 3, 2, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 3, N, 0, 1, 0, 0, 0, 0);
        run_table();

        // basic recovery, x0 restore suppressed, inputs ignored while recovering
        phase = 2;
        do_reset();
        add(5, 32'hA, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        add(0, 32'h0, N, N, N, N, 1, N, 0, 0, 0, 0, 0, 0);
        add(7, 32'hB, N, N, N, N, 2, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, 0, 3, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 3, N, 1, 0, 1, 1, 7, 32'hB);
        add(9, 32'h99, 0, N, N, 0, 2, N, 1, 0, 1, 0, 0, 0);
        add(N, 0, N, N, N, N, 1, N, 1, 0, 1, 1, 5, 32'hA);
        add(N, 0, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        run_table();

        // wrap-around recovery from head=tail=6
        phase = 3;
        do_reset();
        add(1, 32'h10, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        add(1, 32'h11, 0, N, N, N, 1, N, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i < 6; i++) add(1, 32'h10 + i, i - 1, N, N, N, i, i - 2, 0, 0, 0, 0, 0, 0);
        add(N, 0, 5, N, N, N, 6, 4, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 6, 5, 0, 0, 0, 0, 0, 0);
        add(10, 32'h60, N, N, N, N, 6, N, 0, 1, 0, 0, 0, 0);
        add(11, 32'h70, N, N, N, N, 7, N, 0, 0, 0, 0, 0, 0);
        add(12, 32'h80, N, N, N, N, 0, N, 0, 0, 0, 0, 0, 0);
        add(13, 32'h90, N, N, N, N, 1, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, 7, 2, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, 6, N, N, N, 2, N, 1, 0, 1, 1, 13, 32'h90);
        add(N, 0, N, N, N, N, 1, N, 1, 0, 1, 1, 12, 32'h80);
        add(N, 0, N, N, N, N, 0, N, 1, 0, 1, 1, 11, 32'h70);
        add(N, 0, N, N, N, N, 7, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, 6, N, N, N, 7, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 7, 6, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 7, N, 0, 1, 0, 0, 0, 0);
        run_table();

        // triple completion of one id with alloc at count 7; exception beats alloc
        phase = 4;
        do_reset();
        for (int i = 0; i < 7; i++) add(i + 1, 32'h500 + i, N, N, N, N, i, N, 0, int'(i == 0), 0, 0, 0, 0);
        add(20, 32'h5007, 3, 3, 3, N, 7, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, 0, 1, 2, N, 0, N, 1, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, 0, 1, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, 1, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, 2, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, 3, 0, 0, 0, 0, 0, 0);
        add(21, 32'h55, N, N, N, 5, 0, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, N, 1, 0, 1, 1, 20, 32'h5007);
        add(N, 0, N, N, N, N, 7, N, 1, 0, 1, 1, 7, 32'h506);
        add(N, 0, N, N, N, N, 6, N, 1, 0, 1, 1, 6, 32'h505);
        add(N, 0, N, N, N, 6, 5, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 5, N, 0, 0, 0, 0, 0, 0);
        run_table();
`ifdef HF_STATS_EN
        check("retired_cnt", retired_cnt_o, 32'd4);
        check("recovery_cnt", recovery_cnt_o, 32'd1);
`endif

        // reset asserted during the second of four recovery cycles
        phase = 5;
        do_reset();
        for (int i = 0; i < 4; i++) add(i + 1, 32'h60 + i, N, N, N, N, i, N, 0, int'(i == 0), 0, 0, 0, 0);
        add(N, 0, N, N, N, 0, 4, N, 0, 0, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 4, N, 1, 0, 1, 1, 4, 32'h63);
        run_table();
`ifdef HF_STATS_EN
        check("recovery_cnt_pre_rst", recovery_cnt_o, 32'd1);
`endif
        rst_i = 1'b1;
        add(N, 0, N, N, N, N, 3, N, 1, 0, 1, 1, 3, 32'h62);
        run_table();
        rst_i = 1'b0;
        add(N, 0, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        add(N, 0, N, N, N, N, 0, N, 0, 1, 0, 0, 0, 0);
        run_table();
`ifdef HF_STATS_EN
        check("retired_cnt_rst", retired_cnt_o, 32'd0);
        check("recovery_cnt_rst", recovery_cnt_o, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
